uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default bit timing.
// Pure constants and types; no latency or flow control of its own.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS           = 8;
    localparam int DEFAULT_CLK_PER_BIT = 435;
    localparam int DEFAULT_FIFO_DEPTH  = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for transmit bytes; read data is the head entry, valid whenever not empty.
// Backpressure: full blocks pushes even when a pop happens on the same edge; pop while empty is ignored.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a same-cycle pop never frees a slot for the push.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter; tx falls one clock after a byte lands in an idle, empty buffer.
// Backpressure: ready is the buffer's registered not-full flag; frames follow each other with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int                 CW       = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]      CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [2:0]         BIT_LAST = 3'(DATA_BITS - 1);
    localparam int                 FCW      = $clog2(FIFO_DEPTH) + 1;

    state_t                state_q,   state_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q,   shift_d;
    logic                  tx_q,      tx_d;

    logic                  fifo_pop;
    logic [DATA_BITS-1:0]  fifo_dat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCW-1:0]        fifo_count;
    logic                  bit_end;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (valid),
        .push_dat (data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign ready = !fifo_full;
    assign tx    = tx_q;
    assign busy  = (state_q != IDLE) || (fifo_count != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        bit_end   = (cnt_q == CNT_LAST);

        // A new frame is loaded from IDLE at once, or from the final stop-bit cycle to keep frames gapless.
        if (!fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end))) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dat;
            bit_idx_d = '0;
            cnt_d     = '0;
            state_d   = START;
            tx_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    tx_d  = 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        cnt_d   = '0;
                        state_d = DATA;
                        tx_d    = shift_q[0];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            tx_d      = shift_q[bit_idx_d];
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (bit_end) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule
